fib_seq_gen: RTL and testbench
==============================

Name: fib_seq_gen

Overview:
Parametrised generator for Fibonacci-class sequences. It emits `n_terms` terms of the recurrence t[k] = t[k-1] + t[k-2], starting from run-time seeds (0,1 gives Fibonacci; 2,1 gives Lucas).
- Runs are launched by a start handshake.
- Output can be stalled with `en`.
- Arithmetic overflow is handled either by truncating the run or by wrapping, selected per run.
- It sits as a stimulus/datapath source feeding downstream consumers that accept one term per valid cycle.

Parameters:
- WIDTH, 16, bit width of the seeds, the terms and `out`.
- CNT_W, 8, bit width of `n_terms` and `out_index`; the maximum run length is 2^CNT_W - 1.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a new run; sampled only in IDLE.
- seed0  in  WIDTH  term 0; captured when start is accepted.
- seed1  in  WIDTH  term 1; captured when start is accepted.
- n_terms  in  CNT_W  number of terms to emit; captured when start is accepted.
- mode_wrap  in  1  overflow policy (1 = wrap modulo 2^WIDTH, 0 = stop); captured when start is accepted.
- en  in  1  advance enable; 0 stalls RUN.
- out  out  WIDTH  current term (registered).
- out_valid  out  1  `out` and `out_index` are valid this cycle.
- out_index  out  CNT_W  index k of the term on `out`.
- done  out  1  one-cycle pulse coincident with the final out_valid, or alone for an empty run.
- busy  out  1  high while the state is RUN.
- overflow  out  1  sticky overflow flag; cleared on the next accepted start.

Behaviour:
- Reset: state IDLE; all outputs 0; internal registers a, b, the tags a_ovf/b_ovf and the counter all cleared. A reset during RUN aborts the run; no done pulse is produced.
- States: IDLE and RUN only.
- IDLE:
  - start=1 with n_terms != 0: load a=seed0, b=seed1, a_ovf=b_ovf=0, cnt=0; latch n_terms and mode_wrap; clear overflow; go to RUN.
  - start=1 with n_terms = 0: clear overflow; pulse done on the next edge with out_valid=0; stay in IDLE.
- RUN, en=1, one term per edge:
  - Register out=a, out_index=cnt, out_valid=1.
  - Compute {c, s} = a + b at WIDTH+1 bits. Then a<=b, a_ovf<=b_ovf, b<=s[WIDTH-1:0], b_ovf<=c|a_ovf|b_ovf, cnt<=cnt+1.
  - In wrap mode, emitting a term with a_ovf=1 sets overflow.
  - The term is final if cnt == n_terms-1, or if mode_wrap=0 and b_ovf=1. For a final term: done=1 and the state returns to IDLE.
  - Stop mode with truncation: overflow=1, the run ends early, and no overflowed value is ever emitted.
- RUN, en=0: out_valid=0 and done=0; all state holds; `out` keeps its last value.
- Outputs are registered, and out_valid/done are deasserted on every edge that does not emit.
- Latency: start is sampled at edge E0. The first term appears after edge E1 if en=1, so a term has 1 cycle of latency from RUN entry.
- Throughput: one term per cycle while en=1.
- start is ignored while busy. Because the state is IDLE in the done cycle, start is accepted in that same cycle, so back-to-back runs are possible.
- busy is 0 during the done cycle.
- In wrap mode all sums are modulo 2^WIDTH. The run length is always exactly n_terms in wrap mode.

Decomposition:
- Package fib_seq_pkg: state enum (ST_IDLE, ST_RUN), default seed constants (FIB_SEED0=0, FIB_SEED1=1, LUCAS_SEED0=2, LUCAS_SEED1=1).
- Sub-module fib_step: combinational WIDTH-bit adder producing the sum, the carry and the next tags (a_ovf, b_ovf). The sequencing and FSM stay in fib_seq_gen.

Test Plan:
- Fibonacci run: seeds 0,1, n_terms=10, wrap=0, en=1 -> out = 0,1,1,2,3,5,8,13,21,34 with indices 0..9; done with index 9; overflow=0; busy low after the run.
- Stop-mode overflow: seeds 0,1, n_terms=30, wrap=0 -> 25 terms emitted (indices 0..24); last out=46368 with done=1; overflow=1; 75025 is never emitted.
- Wrap-mode overflow: seeds 0,1, n_terms=26, wrap=1 -> index 25 out=9489 (75025-65536) with done=1; overflow rises on that cycle.
- Stall: Lucas seeds 2,1, n_terms=5, en low for 3 cycles after index 1 -> sequence 2,1,3,4,7 with no duplicates or gaps; out_valid=0 during the stall; done with 7.
- Edge cases:
  - n_terms=0 -> a single done pulse, out_valid never set.
  - start asserted during RUN -> ignored.
  - start in the done cycle -> the next run starts immediately.
  - rst asserted mid-run -> all outputs 0 next cycle, no done pulse.

Source files
------------

// File: rtl/fib_seq_pkg.sv
// Shared types and constants for the Fibonacci-class sequence generator.
package fib_seq_pkg;

  // Sequencer states: waiting for a start request, or emitting terms.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Seed pairs for the two best-known members of the family.
  localparam int unsigned FIB_SEED0   = 0;
  localparam int unsigned FIB_SEED1   = 1;
  localparam int unsigned LUCAS_SEED0 = 2;
  localparam int unsigned LUCAS_SEED1 = 1;

endpackage

// File: rtl/fib_step.sv
// One recurrence step: s = a + b with carry, plus propagation of the
// overflow tags that follow each value as it shifts through the a/b pair.
module fib_step #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             a_ovf,
  input  logic             b_ovf,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             next_a_ovf,
  output logic             next_b_ovf
);

  logic [WIDTH:0] full_sum;

  // Widened add so the carry out of the top bit is visible.
  always_comb begin
    full_sum   = {1'b0, a} + {1'b0, b};
    sum        = full_sum[WIDTH-1:0];
    carry      = full_sum[WIDTH];
    // b moves into a, so its tag moves with it.
    next_a_ovf = b_ovf;
    // A sum is tainted if it carried out or either operand was already tainted.
    next_b_ovf = full_sum[WIDTH] | a_ovf | b_ovf;
  end

endmodule

// File: rtl/fib_seq_gen.sv
// Fibonacci-class sequence generator: emits n_terms terms of
// t[k] = t[k-1] + t[k-2] from run-time seeds, one per enabled cycle,
// with per-run choice of stopping at or wrapping through overflow.
module fib_seq_gen
  import fib_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] seed0,
  input  logic [WIDTH-1:0] seed1,
  input  logic [CNT_W-1:0] n_terms,
  input  logic             mode_wrap,
  input  logic             en,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic [CNT_W-1:0] out_index,
  output logic             done,
  output logic             busy,
  output logic             overflow
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             a_ovf_q, a_ovf_d;
  logic             b_ovf_q, b_ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] n_terms_q, n_terms_d;
  logic             mode_wrap_q, mode_wrap_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] out_index_q, out_index_d;
  logic             done_q, done_d;
  logic             overflow_q, overflow_d;

  logic [WIDTH-1:0] step_sum;
  logic             step_carry;
  logic             step_a_ovf;
  logic             step_b_ovf;
  logic             is_final;

  fib_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .a          (a_q),
    .b          (b_q),
    .a_ovf      (a_ovf_q),
    .b_ovf      (b_ovf_q),
    .sum        (step_sum),
    .carry      (step_carry),
    .next_a_ovf (step_a_ovf),
    .next_b_ovf (step_b_ovf)
  );

  // The carry itself is already folded into step_b_ovf.
  logic unused_carry;
  assign unused_carry = step_carry;

  // Last term either by count, or in stop mode because the next term is tainted.
  always_comb begin
    is_final = (cnt_q == (n_terms_q - CNT_W'(1))) || (!mode_wrap_q && b_ovf_q);
  end

  // Next-state and registered-output logic; non-emitting edges drop valid/done.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    a_ovf_d     = a_ovf_q;
    b_ovf_d     = b_ovf_q;
    cnt_d       = cnt_q;
    n_terms_d   = n_terms_q;
    mode_wrap_d = mode_wrap_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    out_index_d = out_index_q;
    done_d      = 1'b0;
    overflow_d  = overflow_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          overflow_d = 1'b0;
          if (n_terms == '0) begin
            // Empty run: a lone done pulse, nothing emitted.
            done_d = 1'b1;
          end else begin
            a_d         = seed0;
            b_d         = seed1;
            a_ovf_d     = 1'b0;
            b_ovf_d     = 1'b0;
            cnt_d       = '0;
            n_terms_d   = n_terms;
            mode_wrap_d = mode_wrap;
            state_d     = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (en) begin
          out_d       = a_q;
          out_index_d = cnt_q;
          out_valid_d = 1'b1;
          a_d         = b_q;
          a_ovf_d     = step_a_ovf;
          b_d         = step_sum;
          b_ovf_d     = step_b_ovf;
          cnt_d       = cnt_q + CNT_W'(1);
          // Wrap mode: flag the first emitted term whose true value exceeded WIDTH bits.
          if (mode_wrap_q && a_ovf_q) begin
            overflow_d = 1'b1;
          end
          // Stop mode: the next term would overflow, so this run is cut here.
          if (!mode_wrap_q && b_ovf_q) begin
            overflow_d = 1'b1;
          end
          if (is_final) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      a_ovf_q     <= 1'b0;
      b_ovf_q     <= 1'b0;
      cnt_q       <= '0;
      n_terms_q   <= '0;
      mode_wrap_q <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      out_index_q <= '0;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      a_ovf_q     <= a_ovf_d;
      b_ovf_q     <= b_ovf_d;
      cnt_q       <= cnt_d;
      n_terms_q   <= n_terms_d;
      mode_wrap_q <= mode_wrap_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      out_index_q <= out_index_d;
      done_q      <= done_d;
      overflow_q  <= overflow_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign out_index = out_index_q;
  assign done      = done_q;
  assign busy      = (state_q == ST_RUN);
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_fib_seq_gen.sv
// Self-checking bench for fib_seq_gen: directed vector table, hand-written
// corner sequences and randomized runs against a true-arithmetic model.
module tb_fib_seq_gen;
  import fib_seq_pkg::*;

  localparam int unsigned W = 16;
  localparam int unsigned C = 8;
  localparam longint unsigned CAP = 64'd1 << W;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] seed0;
  logic [W-1:0] seed1;
  logic [C-1:0] n_terms;
  logic         mode_wrap;
  logic         en;
  logic [W-1:0] out;
  logic         out_valid;
  logic [C-1:0] out_index;
  logic         done;
  logic         busy;
  logic         overflow;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] prev_out = '0;

  fib_seq_gen #(
    .WIDTH (W),
    .CNT_W (C)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .seed0     (seed0),
    .seed1     (seed1),
    .n_terms   (n_terms),
    .mode_wrap (mode_wrap),
    .en        (en),
    .out       (out),
    .out_valid (out_valid),
    .out_index (out_index),
    .done      (done),
    .busy      (busy),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply one run starting now and check every cycle against the model.
  // Returns right after the done cycle is observed so runs can chain back to back.
  task automatic do_run(input logic [W-1:0] s0, input logic [W-1:0] s1, input logic [C-1:0] n,
                        input logic w, input int en_pct, input int stall_after, input bit poke,
                        output int emitted, output logic [W-1:0] last, output logic ovf_end);
    longint unsigned wv[0:256];
    longint unsigned sat[0:256];
    int k;
    int cycles;
    int stall_left;
    bit e;
    bit fin;
    logic ovf_m;

    // True-arithmetic model: wrapped value plus value saturated at 2^W.
    wv[0] = s0; wv[1] = s1;
    sat[0] = s0; sat[1] = s1;
    for (int i = 2; i <= 256; i++) begin
      wv[i]  = (wv[i-1] + wv[i-2]) % CAP;
      sat[i] = (sat[i-1] + sat[i-2] >= CAP) ? CAP : sat[i-1] + sat[i-2];
    end

    emitted = 0;
    last    = prev_out;
    seed0 = s0; seed1 = s1; n_terms = n; mode_wrap = w; start = 1'b1;
    tick();
    if (n == 0) begin
      start = 1'b0;
      check("empty_done", done, 1);
      check("empty_valid", out_valid, 0);
      check("empty_busy", busy, 0);
      check("empty_ovf", overflow, 0);
      tick();
      check("empty_done_once", done, 0);
      check("empty_valid_after", out_valid, 0);
      ovf_end = overflow;
      return;
    end
    check("launch_busy", busy, 1);
    check("launch_valid", out_valid, 0);
    check("launch_done", done, 0);
    check("launch_ovf_clr", overflow, 0);

    start = poke;
    if (poke) begin
      seed0 = W'($urandom); seed1 = W'($urandom); n_terms = C'($urandom_range(1, 200));
      mode_wrap = ~w;
    end
    k = 0; cycles = 0; stall_left = 3; ovf_m = 1'b0;
    while (1) begin
      if (stall_after >= 0 && k == stall_after + 1 && stall_left > 0) begin
        e = 1'b0;
        stall_left--;
      end else begin
        e = ($urandom_range(0, 99) < en_pct);
      end
      en = e;
      tick();
      cycles++;
      if (e) begin
        fin = (k == int'(n) - 1) || (!w && sat[k+1] >= CAP);
        if (w && sat[k] >= CAP) ovf_m = 1'b1;
        if (!w && sat[k+1] >= CAP) ovf_m = 1'b1;
        check("term_valid", out_valid, 1);
        check("term_value", out, wv[k]);
        check("term_index", out_index, k);
        check("term_done", done, fin);
        check("term_ovf", overflow, ovf_m);
        check("term_busy", busy, !fin);
        prev_out = W'(wv[k]);
        last = out;
        emitted++;
        k++;
        if (fin) break;
      end else begin
        check("stall_valid", out_valid, 0);
        check("stall_done", done, 0);
        check("stall_busy", busy, 1);
        check("stall_hold", out, prev_out);
      end
      if (cycles > 2000) begin
        check("run_timeout", 0, 1);
        break;
      end
    end
    start = 1'b0;
    en = 1'b1;
    ovf_end = overflow;
  endtask

  typedef struct {
    logic [W-1:0] s0;
    logic [W-1:0] s1;
    logic [C-1:0] n;
    logic         w;
    int           en_pct;
    int           stall_after;
    bit           poke;
    int           exp_cnt;
    logic [W-1:0] exp_last;
    logic         exp_ovf;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int got_cnt;
    logic [W-1:0] got_last;
    logic got_ovf;
    logic [W-1:0] r0, r1;

    rst = 1'b1; start = 1'b0; seed0 = '0; seed1 = '0; n_terms = '0; mode_wrap = 1'b0; en = 1'b1;
    tick();
    tick();
    check("rst_out", out, 0);
    check("rst_valid", out_valid, 0);
    check("rst_index", out_index, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_ovf", overflow, 0);
    rst = 1'b0;
    tick();

    vecs[0] = '{W'(FIB_SEED0), W'(FIB_SEED1), 8'd10, 1'b0, 100, -1, 1'b1, 10, 16'd34, 1'b0};
    vecs[1] = '{W'(FIB_SEED0), W'(FIB_SEED1), 8'd30, 1'b0, 100, -1, 1'b0, 25, 16'd46368, 1'b1};
    vecs[2] = '{W'(FIB_SEED0), W'(FIB_SEED1), 8'd26, 1'b1, 100, -1, 1'b0, 26, 16'd9489, 1'b1};
    vecs[3] = '{W'(LUCAS_SEED0), W'(LUCAS_SEED1), 8'd5, 1'b0, 100, 1, 1'b0, 5, 16'd7, 1'b0};
    vecs[4] = '{16'd1, 16'd1, 8'd1, 1'b0, 60, -1, 1'b0, 1, 16'd1, 1'b0};
    vecs[5] = '{16'd65535, 16'd1, 8'd3, 1'b1, 100, -1, 1'b0, 3, 16'd0, 1'b1};
    vecs[6] = '{16'd65535, 16'd1, 8'd3, 1'b0, 100, -1, 1'b0, 2, 16'd1, 1'b1};
    vecs[7] = '{16'd0, 16'd1, 8'd0, 1'b0, 100, -1, 1'b0, 0, 16'd0, 1'b0};

    // Runs chain back to back: each starts in the previous run's done cycle.
    for (int i = 0; i < 8; i++) begin
      do_run(vecs[i].s0, vecs[i].s1, vecs[i].n, vecs[i].w, vecs[i].en_pct, vecs[i].stall_after,
             vecs[i].poke, got_cnt, got_last, got_ovf);
      check($sformatf("vec%0d_count", i), got_cnt, vecs[i].exp_cnt);
      if (vecs[i].exp_cnt > 0) check($sformatf("vec%0d_last", i), got_last, vecs[i].exp_last);
      check($sformatf("vec%0d_ovf", i), got_ovf, vecs[i].exp_ovf);
    end
    check("idle_after_runs", busy, 0);

    // Reset in the middle of a run: outputs clear, no done pulse afterwards.
    seed0 = 16'd0; seed1 = 16'd1; n_terms = 8'd20; mode_wrap = 1'b0; start = 1'b1; en = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    tick();
    check("midrst_out", out, 0);
    check("midrst_valid", out_valid, 0);
    check("midrst_index", out_index, 0);
    check("midrst_done", done, 0);
    check("midrst_busy", busy, 0);
    check("midrst_ovf", overflow, 0);
    rst = 1'b0;
    prev_out = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("postrst_done", done, 0);
      check("postrst_valid", out_valid, 0);
    end

    // Randomized runs against the model.
    for (int i = 0; i < 16; i++) begin
      r0 = ($urandom_range(0, 1) == 0) ? W'($urandom_range(0, 5)) : W'($urandom);
      r1 = ($urandom_range(0, 1) == 0) ? W'($urandom_range(0, 5)) : W'($urandom);
      do_run(r0, r1, C'($urandom_range(0, 40)), 1'($urandom_range(0, 1)), 70, -1,
             1'($urandom_range(0, 1)), got_cnt, got_last, got_ovf);
      if ($urandom_range(0, 3) == 0) tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
